// File: rtl/stencil_stream_server_if.sv
// stencil_stream_server_if: host-load and accelerator-read signals of the
// stencil stream server, bundled with master (host/accelerator side) and
// slave (server side) modports.
interface stencil_stream_server_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 7200
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              flush;
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [CNT_W-1:0]  fill;
   logic [CNT_W-1:0]  served;
   logic              done;
   logic              underrun;
   logic [DATA_W-1:0] checksum;

   modport master (
      output flush, ld_valid, ld_data, ld_last, rd_en,
      input  ld_ready, rd_data, rd_valid, fill, served, done, underrun, checksum
   );

   modport slave (
      input  flush, ld_valid, ld_data, ld_last, rd_en,
      output ld_ready, rd_data, rd_valid, fill, served, done, underrun, checksum
   );
endinterface

// File: rtl/stencil_stream_server.sv
// stencil_stream_server: a host loads a frame into local RAM, then the block
// answers each accelerator read_en with the next word one cycle later.
// Optional feature macro: STREAM_SERVER_CHECKSUM_EN (running sum of served words).
module stencil_stream_server #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 7200,
   parameter bit WRAP   = 1'b0
) (
   input logic                   clk,
   input logic                   rst,
   stencil_stream_server_if.slave bus
);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   // Frame storage; never cleared, only overwritten by a new load.
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [1:0]        state_q,    state_d;
   logic [CNT_W-1:0]  fill_q,     fill_d;
   logic [CNT_W-1:0]  served_q,   served_d;
   logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [DATA_W-1:0] rd_data_q,  rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              underrun_q, underrun_d;

   logic ld_ready;
   logic ld_fire;
   logic rd_fire;
   logic rd_last;

   // A flush cycle refuses load words so a handshake never lands while the
   // serve pointer is being restarted.
   assign ld_ready = (state_q == ST_LOAD) && !bus.flush;
   assign ld_fire  = ld_ready && bus.ld_valid;
   assign rd_fire  = (state_q == ST_SERVE) && bus.rd_en && !bus.flush;
   // SERVE is only ever entered with fill > 0, so fill-1 cannot underflow here.
   assign rd_last  = (CNT_W'(rd_ptr_q) == (fill_q - ONE));

   // Next-state: flush wins over loads and reads, reads advance the pointer.
   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      served_d   = served_q;
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      underrun_d = underrun_q;

      if (bus.flush) begin
         rd_ptr_d   = '0;
         served_d   = '0;
         underrun_d = 1'b0;
         state_d    = (fill_q != '0) ? ST_SERVE : ST_LOAD;
      end else begin
         if (ld_fire) begin
            fill_d = fill_q + ONE;
            if (bus.ld_last || (fill_q == LAST_SLOT)) state_d = ST_SERVE;
         end

         if (rd_fire) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            if (rd_last) begin
               if (WRAP) begin
                  rd_ptr_d = '0;
                  served_d = '0;
               end else begin
                  // Pointer parked at the last word; it is unused in DONE and
                  // would overflow ADDR_W for a full-depth frame.
                  served_d = served_q + ONE;
                  state_d  = ST_DONE;
               end
            end else begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               served_d = served_q + ONE;
            end
         end

         if (bus.rd_en && (state_q != ST_SERVE)) underrun_d = 1'b1;
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         fill_q     <= '0;
         served_q   <= '0;
         rd_ptr_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         served_q   <= served_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         underrun_q <= underrun_d;
      end
   end

   // RAM write port, addressed by the running fill count.
   always_ff @(posedge clk) begin
      if (!rst && ld_fire) mem_q[fill_q[ADDR_W-1:0]] <= bus.ld_data;
   end

`ifdef STREAM_SERVER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   // Running modulo sum of every word presented with rd_valid.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) checksum_q <= '0;
      else if (rd_valid_q)  checksum_q <= checksum_q + rd_data_q;
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = '0;
`endif

   assign bus.ld_ready = ld_ready;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.fill     = fill_q;
   assign bus.served   = served_q;
   assign bus.done     = (state_q == ST_DONE);
   assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_stencil_stream_server.sv
// tb_stencil_stream_server: directed bench for the stencil stream server.
// Two instances share the clock: u0 stops at frame end, u1 wraps around.
module tb_stencil_stream_server;
   localparam int DW = 16;
   localparam int DP = 8;

`ifdef STREAM_SERVER_CHECKSUM_EN
   localparam int EXP_SUM = 46;
`else
   localparam int EXP_SUM = 0;
`endif

   logic clk = 1'b0;
   logic rst0, rst1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   stencil_stream_server_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
   stencil_stream_server_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

   stencil_stream_server #(.DATA_W(DW), .DEPTH(DP), .WRAP(1'b0)) u0 (
      .clk(clk), .rst(rst0), .bus(if0.slave));
   stencil_stream_server #(.DATA_W(DW), .DEPTH(DP), .WRAP(1'b1)) u1 (
      .clk(clk), .rst(rst1), .bus(if1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int w0 [6];
      w0 = '{10, 11, 12, 13, 10, 11};

      rst0 = 1'b1; rst1 = 1'b1;
      if0.flush = 0; if0.ld_valid = 0; if0.ld_data = '0; if0.ld_last = 0; if0.rd_en = 0;
      if1.flush = 0; if1.ld_valid = 0; if1.ld_data = '0; if1.ld_last = 0; if1.rd_en = 0;
      tick(); tick();
      rst0 = 1'b0; rst1 = 1'b0;

      // reset state
      chk("rst_ld_ready", if0.ld_ready, 1);
      chk("rst_rd_valid", if0.rd_valid, 0);
      chk("rst_rd_data",  if0.rd_data, 0);
      chk("rst_fill",     if0.fill, 0);
      chk("rst_served",   if0.served, 0);
      chk("rst_done",     if0.done, 0);
      chk("rst_underrun", if0.underrun, 0);
      chk("rst_checksum", if0.checksum, 0);

      // 1: load 10..13, ld_last on 13, into both instances
      for (int v = 10; v <= 13; v++) begin
         if0.ld_valid = 1; if0.ld_data = DW'(v); if0.ld_last = (v == 13);
         if1.ld_valid = 1; if1.ld_data = DW'(v); if1.ld_last = (v == 13);
         tick();
      end
      if0.ld_valid = 0; if0.ld_last = 0;
      if1.ld_valid = 0; if1.ld_last = 0;
      chk("load_fill",     if0.fill, 4);
      chk("load_ld_ready", if0.ld_ready, 0);
      chk("load_done",     if0.done, 0);

      // 2: four back-to-back reads, one cycle latency
      if0.rd_en = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rd_valid", if0.rd_valid, 1);
         chk("rd_data",  if0.rd_data, 10 + i);
         chk("served",   if0.served, i + 1);
      end
      chk("frame_done", if0.done, 1);

      // 3: fifth read past the end of a non-wrapping frame
      tick();
      if0.rd_en = 0;
      chk("over_underrun", if0.underrun, 1);
      chk("over_rd_valid", if0.rd_valid, 0);
      chk("over_rd_data",  if0.rd_data, 13);
      chk("checksum",      if0.checksum, EXP_SUM);

      // 4: flush with rd_en in the same cycle drops the read
      if0.flush = 1; if0.rd_en = 1;
      tick();
      if0.flush = 0; if0.rd_en = 0;
      chk("flush_underrun", if0.underrun, 0);
      chk("flush_rd_valid", if0.rd_valid, 0);
      chk("flush_served",   if0.served, 0);
      chk("flush_done",     if0.done, 0);
      chk("flush_checksum", if0.checksum, 0);
      chk("flush_ld_ready", if0.ld_ready, 0);
      if0.rd_en = 1;
      tick();
      if0.rd_en = 0;
      chk("reread_valid", if0.rd_valid, 1);
      chk("reread_data",  if0.rd_data, 10);
      tick();
      chk("hold_valid", if0.rd_valid, 0);
      chk("hold_data",  if0.rd_data, 10);

      // 6: reset in the middle of serving
      if0.rd_en = 1;
      tick();
      chk("mid_data", if0.rd_data, 11);
      if0.rd_en = 0; rst0 = 1;
      tick();
      rst0 = 0;
      chk("mrst_ld_ready", if0.ld_ready, 1);
      chk("mrst_rd_valid", if0.rd_valid, 0);
      chk("mrst_rd_data",  if0.rd_data, 0);
      chk("mrst_fill",     if0.fill, 0);
      chk("mrst_served",   if0.served, 0);
      chk("mrst_done",     if0.done, 0);
      chk("mrst_underrun", if0.underrun, 0);
      chk("mrst_checksum", if0.checksum, 0);
      if0.rd_en = 1;
      tick();
      if0.rd_en = 0;
      chk("load_rd_underrun", if0.underrun, 1);
      chk("load_rd_valid",    if0.rd_valid, 0);

      // full-depth frame without ld_last ends the load on the DEPTH-th word
      for (int i = 0; i < DP; i++) begin
         if0.ld_valid = 1; if0.ld_data = DW'(100 + i);
         tick();
      end
      chk("full_fill",     if0.fill, DP);
      chk("full_ld_ready", if0.ld_ready, 0);
      if0.ld_data = DW'(999);
      tick();
      if0.ld_valid = 0;
      chk("full_ignore_fill", if0.fill, DP);
      if0.rd_en = 1;
      for (int i = 0; i < DP; i++) begin
         tick();
         chk("full_rd_data", if0.rd_data, 100 + i);
      end
      if0.rd_en = 0;
      chk("full_served", if0.served, DP);
      chk("full_done",   if0.done, 1);
      chk("full_underrun_kept", if0.underrun, 1);

      // flush out of DONE restarts serving from word 0
      if0.flush = 1;
      tick();
      if0.flush = 0;
      chk("dflush_done", if0.done, 0);
      if0.rd_en = 1;
      tick();
      if0.rd_en = 0;
      chk("dflush_rd_data", if0.rd_data, 100);

      // 5: wrapping instance, six reads over a four-word frame
      chk("wrap_fill", if1.fill, 4);
      if1.rd_en = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("wrap_rd_data",  if1.rd_data, w0[i]);
         chk("wrap_rd_valid", if1.rd_valid, 1);
         chk("wrap_done",     if1.done, 0);
      end
      if1.rd_en = 0;
      chk("wrap_served",   if1.served, 2);
      chk("wrap_underrun", if1.underrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
